mem_stage_lsu: RTL and testbench
================================

Name: mem_stage_lsu

Overview:
Parametrised successor to the MEM pipeline stage. It turns load/store commands from EX into a variable-latency memory-bus transaction with a req/ready handshake and stalls the pipeline while the bus is busy. Bytes are placed in the correct lane by address offset, and stores produce byte enables. Misalignment and bus timeout are detected and reported as RISC-V exceptions. Non-memory operations pass through to WB with one-cycle latency.

Parameters:
XLEN, 32, datapath width; legal values are 32 and 64.
TIMEOUT, 15, maximum BUSY cycles without bus_ready before an access fault is raised.

Ports:
clk  in  1  clock; all logic is clocked on the rising edge.
rst_n  in  1  synchronous, active-low reset.
in_valid  in  1  EX presents a valid instruction.
in_reg_d  in  5  destination register.
in_mem_command  in  5  [0]=memory access, [1]=write, [4:2]=funct3.
in_alu_out  in  XLEN  effective address, or pass-through result.
in_mem_write_data  in  XLEN  store data (rs2).
in_now_pc  in  XLEN  instruction PC.
stall  out  1  combinational; upstream must hold all in_* while this is 1.
bus_req  out  1  transaction request.
bus_we  out  1  1=write.
bus_addr  out  XLEN  word-aligned address (low log2(XLEN/8) bits are 0).
bus_wdata  out  XLEN  lane-shifted store data.
bus_be  out  XLEN/8  byte enables.
bus_ready  in  1  transaction complete; read data is valid in the same cycle.
bus_rdata  in  XLEN  read data.
out_valid  out  1  one-cycle pulse; WB fields are valid.
out_wb_data  out  XLEN  write-back value.
out_reg_d  out  5  destination register.
out_now_pc  out  XLEN  PC of the completing instruction.
out_exc  out  1  exception pulse, concurrent with out_valid.
out_exc_cause  out  4  4/6 = load/store misaligned; 5/7 = load/store access fault.
out_exc_addr  out  XLEN  faulting effective address.

Behaviour:
- Reset (rst_n=0 at an edge): state=IDLE, timeout counter=0, and every registered output is 0 (bus_req, bus_we, bus_addr, bus_wdata, bus_be, out_*).
- Reset mid-transaction: bus_req drops at that edge; no out_valid is produced; a late bus_ready is ignored.
- Accept condition: state==IDLE and in_valid=1.
- Size from funct3[1:0]: 0=byte, 1=half, 2=word, 3=dword.
  - funct3[1:0]=3 is legal only when XLEN=64; otherwise it is an access fault, raised immediately with no bus cycle.
  - Store funct3 must have bit 2 = 0; otherwise it is a store access fault, raised immediately.
- Misaligned: the effective address is not a multiple of the size.
  - Raised with one-cycle latency: out_valid=1, out_exc=1, cause 4 (load) or 6 (store), out_exc_addr=in_alu_out.
  - No bus cycle is issued.
- Non-memory op (cmd[0]=0): 1-cycle latency; out_wb_data=in_alu_out, out_valid=1, out_exc=0, stall=0.
- Aligned memory op in IDLE:
  - At the edge, latch bus_addr, bus_we=cmd[1] and bus_be.
  - bus_be = the size mask shifted left by the address offset.
  - bus_wdata = in_mem_write_data shifted left by 8×offset.
  - bus_req goes to 1; state goes to BUSY; counter cleared.
- stall = (IDLE & accept & aligned memory op) | (BUSY & ~bus_ready).
- BUSY:
  - bus_req and all bus_* outputs stay constant; the counter increments each cycle.
  - On bus_ready:
    - bus_req drops to 0 at that edge; state returns to IDLE; out_valid=1.
    - Loads: extract the lane at offset; sign-extend for funct3 bit 2 = 0, zero-extend for funct3 bit 2 = 1.
    - Stores: out_wb_data=effective address, matching the stage's write-back value for stores.
  - Total memory latency = 1 + (cycles until bus_ready).
- Timeout: in BUSY, when counter==TIMEOUT and bus_ready=0:
  - bus_req drops; state returns to IDLE.
  - out_valid=1, out_exc=1, cause 5 or 7, out_exc_addr=effective address.
  - bus_ready arriving exactly on the TIMEOUT cycle wins (normal completion).
- out_reg_d and out_now_pc are latched with the instruction and shown with out_valid.
- When out_valid=0, out_exc=0; the other out_* fields hold their last values.
- bus_ready while IDLE is ignored.

Test Plan:
- Reset: rst_n=0 while BUSY → next cycle bus_req=0, out_valid=0; bus_ready pulsed afterwards → no out_valid.
- lb/lbu: addr 0x1003, bus_rdata=0x80FF_1234, ready after 2 cycles → out_wb_data 0xFFFFFF80 / 0x00000080; stall high 3 cycles.
- sh: addr 0x2002, rs2=0xABCD → bus_be=4'b1100, bus_wdata=0xABCD0000, bus_we=1, out_wb_data=0x2002.
- Misaligned: lw @0x1001 → out_exc=1, cause 4, out_exc_addr 0x1001, bus_req never asserted.
- Timeout: TIMEOUT=15, sw with bus_ready held 0 → access fault (cause 7) after 16 BUSY cycles; bus_ready on cycle 15 instead → normal completion, no exc.
- Back-to-back: add, lw (ready at 0 wait), add → out_valid pulses in order, PCs preserved, no dropped instruction.

Source files
------------

// File: rtl/mem_stage_lsu.sv
// Load/store memory stage: issues req/ready bus transactions, aligns byte lanes,
// and reports misalignment/access-fault exceptions; non-memory ops pass through in one cycle.
module mem_stage_lsu #(
  parameter int unsigned XLEN    = 32,
  parameter int unsigned TIMEOUT = 15
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  input  logic [4:0]        in_reg_d,
  input  logic [4:0]        in_mem_command,
  input  logic [XLEN-1:0]   in_alu_out,
  input  logic [XLEN-1:0]   in_mem_write_data,
  input  logic [XLEN-1:0]   in_now_pc,
  output logic              stall,
  output logic              bus_req,
  output logic              bus_we,
  output logic [XLEN-1:0]   bus_addr,
  output logic [XLEN-1:0]   bus_wdata,
  output logic [XLEN/8-1:0] bus_be,
  input  logic              bus_ready,
  input  logic [XLEN-1:0]   bus_rdata,
  output logic              out_valid,
  output logic [XLEN-1:0]   out_wb_data,
  output logic [4:0]        out_reg_d,
  output logic [XLEN-1:0]   out_now_pc,
  output logic              out_exc,
  output logic [3:0]        out_exc_cause,
  output logic [XLEN-1:0]   out_exc_addr
);

  localparam int unsigned NB = XLEN / 8;
  localparam int unsigned OW = $clog2(NB);
  localparam int unsigned CW = $clog2(TIMEOUT + 2);

  typedef enum logic [0:0] {StIdle, StBusy} state_e;

  state_e            state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic              req_q, req_d, we_q, we_d;
  logic [XLEN-1:0]   addr_q, addr_d, wdata_q, wdata_d;
  logic [NB-1:0]     be_q, be_d;
  logic              ov_q, ov_d, exc_q, exc_d;
  logic [XLEN-1:0]   wb_q, wb_d, pc_q, pc_d, ea_q, ea_d;
  logic [4:0]        rd_q, rd_d;
  logic [3:0]        cause_q, cause_d;
  // Context of the instruction currently occupying the bus.
  logic [2:0]        pf3_q, pf3_d;
  logic [OW-1:0]     poff_q, poff_d;
  logic [XLEN-1:0]   pea_q, pea_d, ppc_q, ppc_d;
  logic [4:0]        prd_q, prd_d;

  logic              is_mem, is_wr, size_bad, misaligned;
  logic [2:0]        f3;
  logic [1:0]        sz;
  logic [OW-1:0]     off, amask;
  logic [NB-1:0]     smask;
  logic [XLEN-1:0]   rshift, load_val;

  assign is_mem = in_mem_command[0];
  assign is_wr  = in_mem_command[1];
  assign f3     = in_mem_command[4:2];
  assign sz     = f3[1:0];
  assign off    = in_alu_out[OW-1:0];

  always_comb begin
    unique case (sz)
      2'd0:    begin amask = '0;       smask = NB'(8'h01); end
      2'd1:    begin amask = OW'(1);   smask = NB'(8'h03); end
      2'd2:    begin amask = OW'(3);   smask = NB'(8'h0F); end
      default: begin amask = OW'(7);   smask = NB'(8'hFF); end
    endcase
  end

  assign size_bad   = ((sz == 2'd3) && (XLEN == 32)) || (is_wr && f3[2]);
  assign misaligned = |(off & amask);

  assign rshift = bus_rdata >> {poff_q, 3'b000};

  always_comb begin
    load_val = rshift;
    unique case (pf3_q[1:0])
      2'd0: begin
        if (pf3_q[2]) load_val = XLEN'(rshift[7:0]);
        else          load_val = XLEN'($signed(rshift[7:0]));
      end
      2'd1: begin
        if (pf3_q[2]) load_val = XLEN'(rshift[15:0]);
        else          load_val = XLEN'($signed(rshift[15:0]));
      end
      2'd2: begin
        if (pf3_q[2]) load_val = XLEN'(rshift[31:0]);
        else          load_val = XLEN'($signed(rshift[31:0]));
      end
      default: load_val = rshift;
    endcase
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    req_d   = req_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    be_d    = be_q;
    ov_d    = 1'b0;
    exc_d   = 1'b0;
    wb_d    = wb_q;
    pc_d    = pc_q;
    rd_d    = rd_q;
    ea_d    = ea_q;
    cause_d = cause_q;
    pf3_d   = pf3_q;
    poff_d  = poff_q;
    pea_d   = pea_q;
    ppc_d   = ppc_q;
    prd_d   = prd_q;
    stall   = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (in_valid) begin
          if (!is_mem) begin
            ov_d = 1'b1;
            wb_d = in_alu_out;
            rd_d = in_reg_d;
            pc_d = in_now_pc;
          end else if (size_bad || misaligned) begin
            ov_d  = 1'b1;
            exc_d = 1'b1;
            rd_d  = in_reg_d;
            pc_d  = in_now_pc;
            ea_d  = in_alu_out;
            // Access fault (5/7) outranks misalignment (4/6).
            if (size_bad) cause_d = is_wr ? 4'd7 : 4'd5;
            else          cause_d = is_wr ? 4'd6 : 4'd4;
          end else begin
            stall   = 1'b1;
            state_d = StBusy;
            cnt_d   = '0;
            req_d   = 1'b1;
            we_d    = is_wr;
            addr_d  = in_alu_out & ~XLEN'(NB - 1);
            be_d    = smask << off;
            wdata_d = in_mem_write_data << {off, 3'b000};
            pf3_d   = f3;
            poff_d  = off;
            pea_d   = in_alu_out;
            ppc_d   = in_now_pc;
            prd_d   = in_reg_d;
          end
        end
      end
      default: begin
        if (bus_ready) begin
          state_d = StIdle;
          req_d   = 1'b0;
          ov_d    = 1'b1;
          wb_d    = we_q ? pea_q : load_val;
          rd_d    = prd_q;
          pc_d    = ppc_q;
        end else if (cnt_q == CW'(TIMEOUT)) begin
          stall   = 1'b1;
          state_d = StIdle;
          req_d   = 1'b0;
          ov_d    = 1'b1;
          exc_d   = 1'b1;
          cause_d = we_q ? 4'd7 : 4'd5;
          ea_d    = pea_q;
          rd_d    = prd_q;
          pc_d    = ppc_q;
        end else begin
          stall = 1'b1;
          cnt_d = cnt_q + CW'(1);
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      req_q   <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      be_q    <= '0;
      ov_q    <= 1'b0;
      exc_q   <= 1'b0;
      wb_q    <= '0;
      pc_q    <= '0;
      rd_q    <= '0;
      ea_q    <= '0;
      cause_q <= '0;
      pf3_q   <= '0;
      poff_q  <= '0;
      pea_q   <= '0;
      ppc_q   <= '0;
      prd_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      req_q   <= req_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      be_q    <= be_d;
      ov_q    <= ov_d;
      exc_q   <= exc_d;
      wb_q    <= wb_d;
      pc_q    <= pc_d;
      rd_q    <= rd_d;
      ea_q    <= ea_d;
      cause_q <= cause_d;
      pf3_q   <= pf3_d;
      poff_q  <= poff_d;
      pea_q   <= pea_d;
      ppc_q   <= ppc_d;
      prd_q   <= prd_d;
    end
  end

  assign bus_req       = req_q;
  assign bus_we        = we_q;
  assign bus_addr      = addr_q;
  assign bus_wdata     = wdata_q;
  assign bus_be        = be_q;
  assign out_valid     = ov_q;
  assign out_wb_data   = wb_q;
  assign out_reg_d     = rd_q;
  assign out_now_pc    = pc_q;
  assign out_exc       = exc_q;
  assign out_exc_cause = cause_q;
  assign out_exc_addr  = ea_q;

endmodule

// File: tb/tb_mem_stage_lsu.sv
// Bench for mem_stage_lsu (XLEN=32): scenario tasks drive stimulus and check bus-side
// behaviour; a monitor pops expected write-back results from a scoreboard queue.
module tb_mem_stage_lsu;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic [4:0]  in_reg_d;
  logic [4:0]  in_mem_command;
  logic [31:0] in_alu_out, in_mem_write_data, in_now_pc;
  logic        stall, bus_req, bus_we, bus_ready;
  logic [31:0] bus_addr, bus_wdata, bus_rdata;
  logic [3:0]  bus_be;
  logic        out_valid, out_exc;
  logic [31:0] out_wb_data, out_now_pc, out_exc_addr;
  logic [4:0]  out_reg_d;
  logic [3:0]  out_exc_cause;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [31:0] wb;
    logic [4:0]  rd;
    logic [31:0] pc;
    logic        exc;
    logic [3:0]  cause;
    logic [31:0] ea;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;

  mem_stage_lsu #(.XLEN(32), .TIMEOUT(15)) dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .in_valid          (in_valid),
    .in_reg_d          (in_reg_d),
    .in_mem_command    (in_mem_command),
    .in_alu_out        (in_alu_out),
    .in_mem_write_data (in_mem_write_data),
    .in_now_pc         (in_now_pc),
    .stall             (stall),
    .bus_req           (bus_req),
    .bus_we            (bus_we),
    .bus_addr          (bus_addr),
    .bus_wdata         (bus_wdata),
    .bus_be            (bus_be),
    .bus_ready         (bus_ready),
    .bus_rdata         (bus_rdata),
    .out_valid         (out_valid),
    .out_wb_data       (out_wb_data),
    .out_reg_d         (out_reg_d),
    .out_now_pc        (out_now_pc),
    .out_exc           (out_exc),
    .out_exc_cause     (out_exc_cause),
    .out_exc_addr      (out_exc_addr)
  );

  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  // Scoreboard monitor: every out_valid pulse must match the oldest expectation.
  always @(posedge clk) begin
    #2;
    if (out_valid) begin
      total++;
      if (sb.size() == 0) begin
        bad++;
        $display("FAIL spurious_out_valid: got pc=%h rd=%0d, expected no output", out_now_pc,
                 out_reg_d);
      end else begin
        mon_e = sb.pop_front();
        if (mon_e.exc) begin
          if ({out_exc, out_exc_cause, out_exc_addr, out_reg_d, out_now_pc} !==
              {1'b1, mon_e.cause, mon_e.ea, mon_e.rd, mon_e.pc}) begin
            bad++;
            $display("FAIL exc_result: got exc=%b cause=%0d ea=%h rd=%0d pc=%h, expected cause=%0d ea=%h rd=%0d pc=%h",
                     out_exc, out_exc_cause, out_exc_addr, out_reg_d, out_now_pc,
                     mon_e.cause, mon_e.ea, mon_e.rd, mon_e.pc);
          end
        end else begin
          if ({out_exc, out_wb_data, out_reg_d, out_now_pc} !==
              {1'b0, mon_e.wb, mon_e.rd, mon_e.pc}) begin
            bad++;
            $display("FAIL wb_result: got exc=%b wb=%h rd=%0d pc=%h, expected exc=0 wb=%h rd=%0d pc=%h",
                     out_exc, out_wb_data, out_reg_d, out_now_pc, mon_e.wb, mon_e.rd, mon_e.pc);
          end
        end
      end
    end else if (out_exc) begin
      total++;
      bad++;
      $display("FAIL exc_without_valid: got out_exc=1, expected 0");
    end
  end

  function automatic exp_t mk(input logic [31:0] wb, input logic [4:0] rd, input logic [31:0] pc,
                              input logic exc, input logic [3:0] cause, input logic [31:0] ea);
    exp_t e;
    e.wb = wb; e.rd = rd; e.pc = pc; e.exc = exc; e.cause = cause; e.ea = ea;
    return e;
  endfunction

  function automatic logic [31:0] load_model(input logic [31:0] rdata, input logic [1:0] off,
                                             input logic [2:0] f3);
    logic [31:0] s;
    s = rdata >> (8 * off);
    case (f3)
      3'b000:  return {{24{s[7]}}, s[7:0]};
      3'b001:  return {{16{s[15]}}, s[15:0]};
      3'b100:  return {24'h0, s[7:0]};
      3'b101:  return {16'h0, s[15:0]};
      default: return s;
    endcase
  endfunction

  // Presents one memory instruction for its accept cycle; returns whether stall was high.
  task automatic accept(input logic [4:0] cmd, input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [4:0] rd, input logic [31:0] pc, output int stl);
    in_mem_command = cmd; in_alu_out = addr; in_mem_write_data = wdata;
    in_reg_d = rd; in_now_pc = pc; in_valid = 1'b1; bus_ready = 1'b0;
    #1;
    stl = stall ? 1 : 0;
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  // Holds bus_ready low for 'waits' cycles then completes; counts stall-high cycles.
  task automatic finish_access(input int waits, input logic [31:0] rdata, output int stalls);
    stalls = 0;
    for (int i = 0; i < waits; i++) begin
      bus_ready = 1'b0; #1;
      if (stall) stalls++;
      @(posedge clk); #1;
    end
    bus_ready = 1'b1; bus_rdata = rdata; #1;
    if (stall) stalls++;
    @(posedge clk); #1;
    bus_ready = 1'b0;
  endtask

  task automatic test_reset();
    int s;
    rst_n = 1'b0; in_valid = 1'b0; bus_ready = 1'b0; bus_rdata = '0;
    in_reg_d = '0; in_mem_command = '0; in_alu_out = '0; in_mem_write_data = '0; in_now_pc = '0;
    repeat (2) @(posedge clk);
    #1;
    total++;
    if ({bus_req, bus_we, bus_addr, bus_wdata, bus_be} !== '0) begin
      bad++;
      $display("FAIL reset_bus: got req=%b we=%b addr=%h wdata=%h be=%b, expected all 0",
               bus_req, bus_we, bus_addr, bus_wdata, bus_be);
    end
    total++;
    if ({out_valid, out_exc, out_wb_data, out_reg_d, out_now_pc, out_exc_cause, out_exc_addr}
        !== '0) begin
      bad++;
      $display("FAIL reset_out: got valid=%b exc=%b wb=%h, expected all out_* 0",
               out_valid, out_exc, out_wb_data);
    end
    rst_n = 1'b1;
    @(posedge clk); #1;
    accept(5'b01001, 32'h100, 32'h0, 5'd9, 32'h900, s);
    total++;
    if (bus_req !== 1'b1) begin
      bad++; $display("FAIL reset_pre_busy: got bus_req=%b, expected 1", bus_req);
    end
    @(posedge clk); #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    total++;
    if ({bus_req, out_valid} !== 2'b00) begin
      bad++; $display("FAIL reset_mid_txn: got req=%b valid=%b, expected 0 0", bus_req, out_valid);
    end
    bus_ready = 1'b1; bus_rdata = 32'hFFFF_FFFF;
    @(posedge clk); #1;
    bus_ready = 1'b0;
    total++;
    if ({bus_req, out_valid} !== 2'b00) begin
      bad++;
      $display("FAIL reset_late_ready: got req=%b valid=%b, expected 0 0", bus_req, out_valid);
    end
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic test_load_byte();
    int s0, s1;
    accept(5'b00001, 32'h1003, 32'h0, 5'd5, 32'h80, s0);
    sb.push_back(mk(32'hFFFF_FF80, 5'd5, 32'h80, 1'b0, 4'd0, 32'h0));
    total++;
    if ({bus_req, bus_we, bus_addr, bus_be} !== {1'b1, 1'b0, 32'h1000, 4'b1000}) begin
      bad++;
      $display("FAIL lb_bus: got req=%b we=%b addr=%h be=%b, expected 1 0 00001000 1000",
               bus_req, bus_we, bus_addr, bus_be);
    end
    finish_access(2, 32'h80FF_1234, s1);
    total++;
    if (s0 + s1 != 3) begin
      bad++; $display("FAIL lb_stall_cycles: got %0d, expected 3", s0 + s1);
    end
    total++;
    if (bus_req !== 1'b0) begin
      bad++; $display("FAIL lb_req_drop: got bus_req=%b, expected 0", bus_req);
    end
    accept(5'b10001, 32'h1003, 32'h0, 5'd6, 32'h84, s0);
    sb.push_back(mk(32'h0000_0080, 5'd6, 32'h84, 1'b0, 4'd0, 32'h0));
    finish_access(2, 32'h80FF_1234, s1);
    total++;
    if (s0 + s1 != 3) begin
      bad++; $display("FAIL lbu_stall_cycles: got %0d, expected 3", s0 + s1);
    end
  endtask

  task automatic test_store_half();
    int s0, s1;
    accept(5'b00111, 32'h2002, 32'h0000_ABCD, 5'd7, 32'h88, s0);
    sb.push_back(mk(32'h2002, 5'd7, 32'h88, 1'b0, 4'd0, 32'h0));
    total++;
    if ({bus_we, bus_be, bus_wdata, bus_addr} !== {1'b1, 4'b1100, 32'hABCD_0000, 32'h2000}) begin
      bad++;
      $display("FAIL sh_bus: got we=%b be=%b wdata=%h addr=%h, expected 1 1100 abcd0000 00002000",
               bus_we, bus_be, bus_wdata, bus_addr);
    end
    total++;
    if (s0 != 1) begin
      bad++; $display("FAIL sh_accept_stall: got %0d, expected 1", s0);
    end
    finish_access(1, 32'h0, s1);
  endtask

  task automatic test_misaligned();
    logic [4:0]  cmds [4] = '{5'b01001, 5'b00111, 5'b01101, 5'b10011};
    logic [31:0] adrs [4] = '{32'h1001, 32'h2001, 32'h3000, 32'h3004};
    logic [3:0]  cause[4] = '{4'd4, 4'd6, 4'd5, 4'd7};
    for (int i = 0; i < 4; i++) begin
      in_mem_command = cmds[i]; in_alu_out = adrs[i]; in_mem_write_data = 32'h5555_5555;
      in_reg_d = 5'(10 + i); in_now_pc = 32'hA0 + 32'(4 * i); in_valid = 1'b1;
      sb.push_back(mk(32'h0, 5'(10 + i), 32'hA0 + 32'(4 * i), 1'b1, cause[i], adrs[i]));
      #1;
      total++;
      if (stall !== 1'b0) begin
        bad++; $display("FAIL exc_stall[%0d]: got stall=%b, expected 0", i, stall);
      end
      @(posedge clk); #1;
      in_valid = 1'b0;
      @(posedge clk); #1;
      total++;
      if (bus_req !== 1'b0) begin
        bad++; $display("FAIL exc_no_bus[%0d]: got bus_req=%b, expected 0", i, bus_req);
      end
    end
  endtask

  task automatic test_timeout();
    int s0, s1, n;
    accept(5'b01011, 32'h300, 32'h1234_5678, 5'd12, 32'hC0, s0);
    sb.push_back(mk(32'h0, 5'd12, 32'hC0, 1'b1, 4'd7, 32'h300));
    n = 0;
    while (bus_req && n < 40) begin
      n++;
      @(posedge clk); #1;
    end
    total++;
    if (n != 16) begin
      bad++; $display("FAIL timeout_busy_cycles: got %0d, expected 16", n);
    end
    accept(5'b01011, 32'h304, 32'h1234_5678, 5'd13, 32'hC4, s0);
    sb.push_back(mk(32'h304, 5'd13, 32'hC4, 1'b0, 4'd0, 32'h0));
    finish_access(15, 32'h0, s1);
    total++;
    if (s1 != 15 || bus_req !== 1'b0) begin
      bad++;
      $display("FAIL timeout_ready_wins: got stalls=%0d req=%b, expected 15 0", s1, bus_req);
    end
  endtask

  task automatic test_back_to_back();
    in_mem_command = 5'b00000; in_alu_out = 32'h11; in_reg_d = 5'd1; in_now_pc = 32'h40;
    in_valid = 1'b1;
    sb.push_back(mk(32'h11, 5'd1, 32'h40, 1'b0, 4'd0, 32'h0));
    #1;
    total++;
    if (stall !== 1'b0) begin
      bad++; $display("FAIL b2b_alu_stall: got %b, expected 0", stall);
    end
    @(posedge clk); #1;
    in_mem_command = 5'b01001; in_alu_out = 32'h500; in_reg_d = 5'd2; in_now_pc = 32'h44;
    sb.push_back(mk(32'hDEAD_BEEF, 5'd2, 32'h44, 1'b0, 4'd0, 32'h0));
    @(posedge clk); #1;
    bus_ready = 1'b1; bus_rdata = 32'hDEAD_BEEF;
    #1;
    total++;
    if (stall !== 1'b0) begin
      bad++; $display("FAIL b2b_ready_stall: got %b, expected 0", stall);
    end
    @(posedge clk); #1;
    bus_ready = 1'b0;
    in_mem_command = 5'b00000; in_alu_out = 32'h22; in_reg_d = 5'd3; in_now_pc = 32'h48;
    sb.push_back(mk(32'h22, 5'd3, 32'h48, 1'b0, 4'd0, 32'h0));
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    total++;
    if (sb.size() != 0) begin
      bad++; $display("FAIL b2b_dropped: got %0d outstanding, expected 0", sb.size());
    end
  endtask

  task automatic test_random_loads();
    int s0, s1;
    logic [1:0]  sz, off;
    logic        u;
    logic [2:0]  f3;
    logic [31:0] addr, rdata;
    logic [3:0]  be;
    for (int i = 0; i < 8; i++) begin
      sz    = 2'($urandom_range(0, 2));
      u     = (sz < 2) ? 1'($urandom_range(0, 1)) : 1'b0;
      off   = (sz == 0) ? 2'($urandom_range(0, 3)) : (sz == 1) ? {1'($urandom_range(0, 1)), 1'b0}
                                                                : 2'b00;
      f3    = {u, sz};
      addr  = ($urandom_range(0, 255) << 4) | 32'(off);
      rdata = $urandom;
      be    = (sz == 0) ? 4'b0001 : (sz == 1) ? 4'b0011 : 4'b1111;
      be    = be << off;
      accept({f3, 2'b01}, addr, 32'h0, 5'(20 + i), 32'h200 + 32'(4 * i), s0);
      sb.push_back(mk(load_model(rdata, off, f3), 5'(20 + i), 32'h200 + 32'(4 * i), 1'b0, 4'd0,
                      32'h0));
      total++;
      if (bus_be !== be || bus_addr !== {addr[31:2], 2'b00}) begin
        bad++;
        $display("FAIL rand_load_bus[%0d]: got be=%b addr=%h, expected be=%b addr=%h",
                 i, bus_be, bus_addr, be, {addr[31:2], 2'b00});
      end
      finish_access(int'($urandom_range(0, 3)), rdata, s1);
    end
  endtask

  initial begin
    test_reset();
    test_load_byte();
    test_store_half();
    test_misaligned();
    test_timeout();
    test_back_to_back();
    test_random_loads();
    repeat (3) @(posedge clk);
    #3;
    total++;
    if (sb.size() != 0) begin
      bad++; $display("FAIL final_outstanding: got %0d, expected 0", sb.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
